// File: rtl/exponent_bit_streamer.sv
// Buffers a multi-word exponent, then serves it one bit at a time (LSB first)
// to the Montgomery exponentiator, advancing on each downstream consume pulse.
module exponent_bit_streamer #(
  parameter int REGISTER_SIZE = 32,
  parameter int EXP_BITS      = 2048
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        start_in,
  input  logic [REGISTER_SIZE-1:0]    word_in,
  input  logic                        word_valid_in,
  output logic                        word_ready_out,
  output logic                        n_bit_out,
  output logic                        bit_valid_out,
  input  logic                        consumed_n_in,
  output logic [$clog2(EXP_BITS)-1:0] bit_index_out,
  output logic                        last_bit_out,
  output logic                        done_out
);

  localparam int WORDS = EXP_BITS / REGISTER_SIZE;
  localparam int WPW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int BPW   = (REGISTER_SIZE > 1) ? $clog2(REGISTER_SIZE) : 1;
  localparam int IDXW  = $clog2(EXP_BITS);
  localparam logic [WPW-1:0] WORD_LAST = WPW'(WORDS - 1);
  localparam logic [BPW-1:0] BIT_LAST  = BPW'(REGISTER_SIZE - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SERVE, DONE} state_t;

  state_t                   state, state_nxt;
  logic [REGISTER_SIZE-1:0] buffer [WORDS];
  logic [REGISTER_SIZE-1:0] cur_word;
  logic [WPW-1:0]           word_cnt, word_ptr, word_ptr_inc;
  logic [BPW-1:0]           bit_ptr;
  logic                     wr_en, advance, at_last, serving;

  always_comb begin
    wr_en        = (state == LOAD) && word_valid_in && !start_in;
    advance      = (state == SERVE) && consumed_n_in && !start_in;
    at_last      = (word_ptr == WORD_LAST) && (bit_ptr == BIT_LAST);
    word_ptr_inc = (word_ptr == WORD_LAST) ? '0 : word_ptr + 1'b1;

    state_nxt = state;
    if (start_in) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        LOAD:    if (wr_en && word_cnt == WORD_LAST) state_nxt = SERVE;
        SERVE:   if (advance && at_last) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    serving        = (state == SERVE);
    word_ready_out = (state == LOAD);
    bit_valid_out  = serving;
    n_bit_out      = serving && cur_word[bit_ptr];
    bit_index_out  = serving ? IDXW'(word_ptr) * IDXW'(REGISTER_SIZE) + IDXW'(bit_ptr) : '0;
    last_bit_out   = serving && at_last;
    done_out       = (state == DONE);
  end

  // Buffer contents are don't-care after reset, so no reset on the array.
  always_ff @(posedge clk_in) begin
    if (wr_en) buffer[word_cnt] <= word_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= IDLE;
      word_cnt <= '0;
      word_ptr <= '0;
      bit_ptr  <= '0;
      cur_word <= '0;
    end else begin
      state <= state_nxt;
      if (start_in) begin
        word_cnt <= '0;
      end else if (wr_en) begin
        word_cnt <= word_cnt + 1'b1;
        if (word_cnt == WORD_LAST) begin
          // With a single word the buffer write lands this same edge, so bypass it.
          cur_word <= (WORDS == 1) ? word_in : buffer[0];
          word_ptr <= '0;
          bit_ptr  <= '0;
        end
      end else if (advance) begin
        if (bit_ptr == BIT_LAST) begin
          bit_ptr  <= '0;
          word_ptr <= word_ptr_inc;
          cur_word <= buffer[word_ptr_inc];
        end else begin
          bit_ptr <= bit_ptr + 1'b1;
        end
      end
    end
  end

endmodule
